pkt_path_arbiter: RTL and testbench

//  Packet-level 2:1 AXI-Stream arbiter. Merges the parser data output (port 0) and the parser

---
 rtl/pkt_path_pkg.sv | 30 +++
 rtl/pkt_path_arbiter_if.sv | 34 +++
 rtl/pkt_path_arbiter.sv | 131 +++++++++++++
 tb/tb_pkt_path_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_path_pkg.sv
// -----------------------------------------------------------------------------
// pkt_path_pkg
// Shared definitions for the packet path arbiter:
//   state_t      - arbiter FSM states (ST_IDLE / ST_BUSY)
//   PORT_DATA    - index of the parser data input  (port 0)
//   PORT_CTRL    - index of the parser control input (port 1)
//   STARVE_W     - width of the starvation counter (limit range 1..255)
//   pick_port()  - packet-level grant decision
// -----------------------------------------------------------------------------
package pkt_path_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  localparam int STARVE_W = 8;

  // Control wins ties unless the data port has already been passed over
  // the maximum number of times.
  function automatic logic pick_port(input logic data_valid,
                                     input logic ctrl_valid,
                                     input logic starved);
    pick_port = (ctrl_valid && !(data_valid && starved)) ? PORT_CTRL : PORT_DATA;
  endfunction

endpackage

// File: rtl/pkt_path_arbiter_if.sv
// -----------------------------------------------------------------------------
// pkt_path_arbiter_if
// AXI-Stream bundle used on every port of the packet path arbiter.
//   tdata  [DW-1:0]   payload
//   tkeep  [DW/8-1:0] byte enables
//   tuser  [UW-1:0]   sideband
//   tvalid / tlast    source-driven qualifiers
//   tready            sink-driven backpressure
// modport master: drives the stream, receives tready.
// modport slave : receives the stream, drives tready.
// -----------------------------------------------------------------------------
interface pkt_path_arbiter_if #(
  parameter int DW = 512,
  parameter int UW = 128
) ();

  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (
    output tdata, tkeep, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/pkt_path_arbiter.sv
// -----------------------------------------------------------------------------
// pkt_path_arbiter
// Packet-level 2:1 AXI-Stream arbiter. Port 0 carries parser data, port 1 the
// parser control traffic. A grant is held for a whole packet, so beats of two
// packets never interleave. Control has priority, bounded by a starvation
// limit that forces a data grant after STARVE_LIMIT consecutive control grants
// taken while data was waiting.
//
// Ports:
//   clk        sole clock
//   rst        synchronous, active-high reset
//   s0_axis    data-path input stream   (slave)
//   s1_axis    control-path input stream (slave)
//   m_axis     merged output stream      (master)
//   pkt_cnt_0  packets forwarded from port 0 (wraps)
//   pkt_cnt_1  packets forwarded from port 1 (wraps)
//
// Timing: the decision is made in IDLE and takes one cycle; the first beat
// follows in BUSY. Returning to IDLE after every packet leaves one idle cycle
// between consecutive packets.
// -----------------------------------------------------------------------------
module pkt_path_arbiter
  import pkt_path_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STARVE_LIMIT         = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pkt_path_arbiter_if.slave    s0_axis,
  pkt_path_arbiter_if.slave    s1_axis,
  pkt_path_arbiter_if.master   m_axis,
  output logic [CNT_WIDTH-1:0] pkt_cnt_0,
  output logic [CNT_WIDTH-1:0] pkt_cnt_1
);

  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_t                r_state;
  logic                  r_grant;
  logic [STARVE_W-1:0]   r_starve;
  logic [CNT_WIDTH-1:0]  r_cnt_0;
  logic [CNT_WIDTH-1:0]  r_cnt_1;

  logic                            w_busy;
  logic                            w_sel_ctrl;
  logic                            w_starved;
  logic                            w_pick;
  logic                            w_tvalid;
  logic                            w_tlast;
  logic                            w_last_hs;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  w_tdata;
  logic [KW-1:0]                   w_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] w_tuser;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_sel_ctrl = (r_grant == PORT_CTRL);
  assign w_starved  = (r_starve == C_STARVE_MAX);
  assign w_pick     = pick_port(s0_axis.tvalid, s1_axis.tvalid, w_starved);

  // Output mux follows the held grant; payload is don't-care while idle
  // because tvalid is forced low there.
  always_comb begin
    w_tdata = s0_axis.tdata;
    w_tkeep = s0_axis.tkeep;
    w_tuser = s0_axis.tuser;
    w_tlast = s0_axis.tlast;
    if (w_sel_ctrl) begin
      w_tdata = s1_axis.tdata;
      w_tkeep = s1_axis.tkeep;
      w_tuser = s1_axis.tuser;
      w_tlast = s1_axis.tlast;
    end
  end

  assign w_tvalid  = w_busy & (w_sel_ctrl ? s1_axis.tvalid : s0_axis.tvalid);
  assign w_last_hs = w_tvalid & m_axis.tready & w_tlast;

  assign m_axis.tdata  = w_tdata;
  assign m_axis.tkeep  = w_tkeep;
  assign m_axis.tuser  = w_tuser;
  assign m_axis.tlast  = w_tlast;
  assign m_axis.tvalid = w_tvalid;

  // Only the granted port sees downstream backpressure; the other is held off.
  assign s0_axis.tready = w_busy & ~w_sel_ctrl & m_axis.tready;
  assign s1_axis.tready = w_busy &  w_sel_ctrl & m_axis.tready;

  assign pkt_cnt_0 = r_cnt_0;
  assign pkt_cnt_1 = r_cnt_1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= PORT_DATA;
      r_starve <= '0;
      r_cnt_0  <= '0;
      r_cnt_1  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s0_axis.tvalid || s1_axis.tvalid) begin
            r_state <= ST_BUSY;
            r_grant <= w_pick;
            if (w_pick == PORT_DATA) begin
              r_starve <= '0;
            end else if (s0_axis.tvalid && !w_starved) begin
              // Only control grants that actually pass over waiting data count.
              r_starve <= r_starve + 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (w_last_hs) begin
            r_state <= ST_IDLE;
            if (w_sel_ctrl) begin
              r_cnt_1 <= r_cnt_1 + 1'b1;
            end else begin
              r_cnt_0 <= r_cnt_0 + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_path_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pkt_path_arbiter
// Self-checking bench for pkt_path_arbiter. A packet-level reference model
// tracks which packet the output should be carrying, and checks every cycle's
// handshake controls, every output beat and both packet counters.
// -----------------------------------------------------------------------------
module tb_pkt_path_arbiter;

  localparam int DW    = 32;
  localparam int UW    = 8;
  localparam int KW    = DW / 8;
  localparam int LIMIT = 4;
  localparam int CW    = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    int             n0;
    int             len0;
    int             n1;
    int             len1;
    bit             rnd_rdy;
    logic [CW-1:0]  exp_c0;
    logic [CW-1:0]  exp_c1;
    bit             exp_first;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] pkt_cnt_0;
  logic [CW-1:0] pkt_cnt_1;

  pkt_path_arbiter_if #(.DW(DW), .UW(UW)) s0_if ();
  pkt_path_arbiter_if #(.DW(DW), .UW(UW)) s1_if ();
  pkt_path_arbiter_if #(.DW(DW), .UW(UW)) m_if ();

  always #5 clk = ~clk;

  pkt_path_arbiter #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .STARVE_LIMIT        (LIMIT),
    .CNT_WIDTH           (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_axis  (s0_if),
    .s1_axis  (s1_if),
    .m_axis   (m_if),
    .pkt_cnt_0(pkt_cnt_0),
    .pkt_cnt_1(pkt_cnt_1)
  );

  int    n_vec  = 0;
  int    n_fail = 0;

  beat_t src_q[2][$];
  beat_t exp_q[2][$];
  bit    hold[2];
  bit    gaps_en;
  bit    rdy_mode;
  bit    rdy_pat[$];
  int    pid;

  // Reference model state (packet level)
  bit    mdl_busy;
  int    mdl_port;
  int    mdl_passed;      // control wins over waiting data since last data win
  int    mdl_cnt[2];
  int    pkt_order[$];
  int    beats_out;
  bit    s1_rdy_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic tready_of(input int p);
    return (p == 0) ? s0_if.tready : s1_if.tready;
  endfunction

  task automatic set_src(input int p, input beat_t b, input logic v);
    if (p == 0) begin
      s0_if.tdata = b.data; s0_if.tkeep = b.keep; s0_if.tuser = b.user;
      s0_if.tlast = b.last; s0_if.tvalid = v;
    end else begin
      s1_if.tdata = b.data; s1_if.tkeep = b.keep; s1_if.tuser = b.user;
      s1_if.tlast = b.last; s1_if.tvalid = v;
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {p[0], 7'(pid), 8'(i), 16'($urandom)};
      b.keep = KW'($urandom);
      b.user = UW'($urandom);
      b.last = (i == len - 1);
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
    pid++;
  endtask

  task automatic model_reset();
    beat_t z;
    z = '0;
    mdl_busy = 0; mdl_port = 0; mdl_passed = 0;
    mdl_cnt[0] = 0; mdl_cnt[1] = 0;
    pkt_order.delete();
    for (int p = 0; p < 2; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      hold[p] = 0;
      set_src(p, z, 1'b0);
    end
  endtask

  // Compares the DUT against the model for the cycle about to be clocked.
  task automatic model_check();
    bit    vv[2];
    beat_t e;
    beat_t a;
    vv[0] = s0_if.tvalid;
    vv[1] = s1_if.tvalid;
    if (s1_if.tready) s1_rdy_seen = 1;
    check("counters", {pkt_cnt_0, pkt_cnt_1}, {CW'(mdl_cnt[0]), CW'(mdl_cnt[1])});
    if (!mdl_busy) begin
      check("idle_ctl", {m_if.tvalid, s0_if.tready, s1_if.tready}, 3'b000);
      if (vv[0] || vv[1]) begin
        if (vv[0] && (!vv[1] || mdl_passed >= LIMIT)) begin
          mdl_port = 0;
          mdl_passed = 0;
        end else begin
          mdl_port = 1;
          if (vv[0] && mdl_passed < LIMIT) mdl_passed++;
        end
        mdl_busy = 1;
        pkt_order.push_back(mdl_port);
      end
    end else begin
      check("busy_ctl", {m_if.tvalid, tready_of(mdl_port), tready_of(1 - mdl_port)},
            {vv[mdl_port], m_if.tready, 1'b0});
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q[mdl_port].size() == 0) begin
          check("beat_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q[mdl_port].pop_front();
          a = {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast};
          check("beat", a, e);
          beats_out++;
          if (e.last) begin
            mdl_busy = 0;
            mdl_cnt[mdl_port]++;
          end
        end
      end
    end
  endtask

  task automatic step();
    bit hs[2];
    @(negedge clk);
    hs[0] = !rst && s0_if.tvalid && s0_if.tready;
    hs[1] = !rst && s1_if.tvalid && s1_if.tready;
    if (!rst) model_check();
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (hs[p]) begin
          void'(src_q[p].pop_front());
          hold[p] = 0;
        end
        if (!hold[p]) begin
          if (src_q[p].size() > 0 && (!gaps_en || $urandom_range(0, 2) != 0)) begin
            set_src(p, src_q[p][0], 1'b1);
            hold[p] = 1;
          end else begin
            if (p == 0) s0_if.tvalid = 1'b0; else s1_if.tvalid = 1'b0;
          end
        end
      end
    end
    if (rdy_pat.size() > 0) m_if.tready = rdy_pat.pop_front();
    else if (rdy_mode) m_if.tready = 1'($urandom_range(0, 1));
    else m_if.tready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    beats_out = 0;
    s1_rdy_seen = 0;
    rdy_pat.delete();
    @(negedge clk);
    check("reset_state", {m_if.tvalid, s0_if.tready, s1_if.tready, pkt_cnt_0, pkt_cnt_1}, '0);
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0 || mdl_busy ||
            exp_q[0].size() > 0 || exp_q[1].size() > 0) && n < budget) begin
      step();
      n++;
    end
    check({name, "_done_in_budget"}, 64'(n < budget), 64'd1);
    step();
    step();
  endtask

  vec_t tbl[6];

  initial begin
    logic [10:0] ord;
    int          tot[2];
    beat_t       z;

    z = '0;
    set_src(0, z, 1'b0);
    set_src(1, z, 1'b0);
    m_if.tready = 1'b1;
    gaps_en = 0; rdy_mode = 0; pid = 0;

    //          n0 len0 n1 len1 rnd  c0     c1     first
    tbl[0] = '{1,  3,   0, 1,   0,   4'd1,  4'd0,  0};  // single 3-beat data packet
    tbl[1] = '{1,  2,   1, 2,   0,   4'd1,  4'd1,  1};  // simultaneous: control first
    tbl[2] = '{1,  1,  10, 1,   0,   4'd1,  4'd10, 1};  // starvation limit
    tbl[3] = '{17, 1,   0, 1,   0,   4'd1,  4'd0,  0};  // counter wrap at 16
    tbl[4] = '{3,  4,   3, 2,   1,   4'd3,  4'd3,  1};  // mixed with backpressure
    tbl[5] = '{0,  1,   5, 3,   0,   4'd0,  4'd5,  1};  // control only

    for (int i = 0; i < 6; i++) begin
      do_reset();
      gaps_en  = 0;
      rdy_mode = tbl[i].rnd_rdy;
      for (int k = 0; k < tbl[i].n0; k++) add_pkt(0, tbl[i].len0);
      for (int k = 0; k < tbl[i].n1; k++) add_pkt(1, tbl[i].len1);
      run_until_done($sformatf("tbl%0d", i), 2000);
      check($sformatf("tbl%0d_cnt0", i), 64'(pkt_cnt_0), 64'(tbl[i].exp_c0));
      check($sformatf("tbl%0d_cnt1", i), 64'(pkt_cnt_1), 64'(tbl[i].exp_c1));
      if (pkt_order.size() > 0)
        check($sformatf("tbl%0d_first", i), 64'(pkt_order[0]), 64'(tbl[i].exp_first));
      else
        check($sformatf("tbl%0d_first", i), 64'd2, 64'(tbl[i].exp_first));
      if (i == 2) begin
        ord = '0;
        foreach (pkt_order[k]) ord = {ord[9:0], pkt_order[k][0]};
        check("starve_order_len", 64'(pkt_order.size()), 64'd11);
        check("starve_order", 64'(ord), 64'(11'b11110111111));
      end
    end

    // Backpressure pattern 1,0,0,1 across a 4-beat data packet
    do_reset();
    rdy_mode = 0;
    for (int k = 0; k < 3; k++) begin
      rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
      rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    end
    add_pkt(0, 4);
    run_until_done("bp", 200);
    check("bp_beats", 64'(beats_out), 64'd4);
    check("bp_cnt0", 64'(pkt_cnt_0), 64'd1);
    check("bp_s1_ready_low", 64'(s1_rdy_seen), 64'd0);

    // Reset pulsed after beat 2 of a 4-beat control packet
    do_reset();
    add_pkt(1, 4);
    for (int n = 0; n < 100 && beats_out < 2; n++) step();
    check("midrst_beats_before", 64'(beats_out), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", {m_if.tvalid, s0_if.tready, s1_if.tready, pkt_cnt_0, pkt_cnt_1}, '0);
    add_pkt(0, 3);
    run_until_done("midrst_fresh", 200);
    check("midrst_cnt", {pkt_cnt_0, pkt_cnt_1}, {4'd1, 4'd0});

    // Randomized traffic with gaps and random backpressure
    do_reset();
    gaps_en = 1;
    rdy_mode = 1;
    tot[0] = 0; tot[1] = 0;
    for (int k = 0; k < 60; k++) begin
      int p;
      p = int'($urandom_range(0, 1));
      add_pkt(p, int'($urandom_range(1, 6)));
      tot[p]++;
    end
    run_until_done("rand", 20000);
    check("rand_cnt", {pkt_cnt_0, pkt_cnt_1}, {CW'(tot[0]), CW'(tot[1])});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
